// File: rtl/prog_delay_pkg.sv
// Shared helpers for the programmable delay line: width derivation,
// delay clamping and explicit (non power-of-2) pointer wrap.
package prog_delay_pkg;

  // Width of a field able to hold 0..max_delay.
  function automatic int calc_dw(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // Width of a pointer addressing 0..max_delay-1 (at least one bit).
  function automatic int calc_aw(input int max_delay);
    return (max_delay > 1) ? $clog2(max_delay) : 1;
  endfunction

  // Requested delays of 0 become 1; anything above max_delay saturates.
  function automatic int clamp_delay(input int cfg, input int max_delay);
    if (cfg < 1) return 1;
    if (cfg > max_delay) return max_delay;
    return cfg;
  endfunction

  // Circular increment with an explicit compare, so any depth works.
  function automatic int ptr_wrap(input int ptr, input int max_delay);
    return (ptr == max_delay - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Stream and configuration signals of the programmable delay line.
interface prog_delay_line_if #(
  parameter int N         = 8,
  parameter int MAX_DELAY = 16
);
  import prog_delay_pkg::*;

  localparam int DW = calc_dw(MAX_DELAY);

  logic          ce;
  logic [N-1:0]  idata;
  logic          ivalid;
  logic [DW-1:0] cfg_delay;
  logic          cfg_load;
  logic [N-1:0]  odata;
  logic          ovalid;
  logic          cfg_busy;
  logic [DW-1:0] cur_delay;

  // Producer / control side.
  modport master (
    output ce, idata, ivalid, cfg_delay, cfg_load,
    input  odata, ovalid, cfg_busy, cur_delay
  );

  // Delay line side.
  modport slave (
    input  ce, idata, ivalid, cfg_delay, cfg_load,
    output odata, ovalid, cfg_busy, cur_delay
  );

endinterface

// File: rtl/prog_delay_line_ram.sv
// DEPTH x {valid, data} storage: synchronous write, registered read that
// returns the old contents when read and write hit the same entry.
module delay_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wvalid,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rvalid,
  output logic [W-1:0]  rdata
);

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             rvalid_q, rvalid_d;
  logic [W-1:0]     rdata_q, rdata_d;

  // Next valid bits and read register; reads see pre-edge contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    vld_d    = vld_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (we) vld_d[waddr] = wvalid;
    if (re) begin
      rvalid_d = vld_q[raddr];
      rdata_d  = mem[raddr];
    end
  end

  // Data array write.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset so it can map to RAM; the separate valid bits carry reset state.
    if (we) mem[waddr] <= wdata;
  end

  // Valid bits and read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      vld_q    <= vld_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/prog_delay_line.sv
// Run-time programmable delay line: {ivalid, idata} re-emerges after
// cur_delay clock-enabled cycles; reconfiguration flushes and refills.
module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter int N             = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 1,
  parameter int DW            = calc_dw(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst,
  prog_delay_line_if.slave bus
);

  localparam int AW = calc_aw(MAX_DELAY);
  localparam int SW = DW + 1;

  logic [AW-1:0] wp_q, wp_d;
  logic [DW-1:0] fc_q, fc_d;
  logic [DW-1:0] cur_delay_q, cur_delay_d;
  logic          out_en_q, out_en_d;
  logic [SW-1:0] rd_sum;
  logic [AW-1:0] rd_addr;
  logic          ram_valid;
  logic [N-1:0]  ram_data;
  logic          ovalid;

  // Pointer advance, saturating fill count and delay reconfiguration.
  always_comb begin
    wp_d        = wp_q;
    fc_d        = fc_q;
    cur_delay_d = cur_delay_q;
    out_en_d    = out_en_q;
    if (bus.ce) begin
      wp_d = AW'(ptr_wrap(int'(wp_q), MAX_DELAY));
      if (fc_q != cur_delay_q) fc_d = fc_q + DW'(1);
      // The read taken on this edge is emitted only once the line is full.
      out_en_d = (fc_d == cur_delay_q);
    end
    if (bus.cfg_load) begin
      cur_delay_d = DW'(clamp_delay(int'(bus.cfg_delay), MAX_DELAY));
      fc_d        = '0;
      out_en_d    = 1'b0;
    end
  end

  // Read index = (wp - cur_delay) mod MAX_DELAY, kept non-negative.
  always_comb begin
    rd_sum = SW'(wp_q) + SW'(MAX_DELAY) - SW'(cur_delay_q);
    if (rd_sum >= SW'(MAX_DELAY)) rd_sum = rd_sum - SW'(MAX_DELAY);
  end

  assign rd_addr = AW'(rd_sum);

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      fc_q        <= '0;
      cur_delay_q <= DW'(DEFAULT_DELAY);
      out_en_q    <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      fc_q        <= fc_d;
      cur_delay_q <= cur_delay_d;
      out_en_q    <= out_en_d;
    end
  end

  delay_ram #(
    .W     (N),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.ce),
    .waddr  (wp_q),
    .wvalid (bus.ivalid),
    .wdata  (bus.idata),
    .re     (bus.ce),
    .raddr  (rd_addr),
    .rvalid (ram_valid),
    .rdata  (ram_data)
  );

  // Gate the registered read so stale or invalid entries read as zero.
  assign ovalid        = out_en_q & ram_valid;
  assign bus.ovalid    = ovalid;
  assign bus.odata     = ovalid ? ram_data : '0;
  assign bus.cfg_busy  = (fc_q != cur_delay_q);
  assign bus.cur_delay = cur_delay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench: a history-queue model of the delay line is compared
// against the DUT after every clock edge, plus literal spot checks.
module tb_prog_delay_line;

  localparam int N    = 8;
  localparam int MAXD = 16;
  localparam int DEFD = 1;
  localparam int DW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_delay_line_if #(.N(N), .MAX_DELAY(MAXD)) bus();

  prog_delay_line #(
    .N             (N),
    .MAX_DELAY     (MAXD),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #2 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every ce edge appends its sample to a history; once D ce edges
  // have passed since reset/load, the output is the sample D ce edges back.
  int         m_d;
  int         m_fc;
  logic       m_v;
  logic [7:0] m_data;
  logic [8:0] hist[$];
  logic [8:0] m_s;

  function automatic int clampf(input int c);
    if (c < 1) return 1;
    if (c > MAXD) return MAXD;
    return c;
  endfunction

  function automatic void model_reset();
    m_d    = DEFD;
    m_fc   = 0;
    m_v    = 1'b0;
    m_data = '0;
    hist.delete();
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.ce) begin
        hist.push_back({bus.ivalid, bus.idata});
        if (hist.size() > 40) void'(hist.pop_front());
        if (m_fc < m_d) m_fc++;
      end
      if (bus.cfg_load) begin
        m_d    = clampf(int'(bus.cfg_delay));
        m_fc   = 0;
        m_v    = 1'b0;
        m_data = '0;
      end else if (bus.ce) begin
        if (m_fc == m_d && hist.size() > m_d) begin
          m_s    = hist[hist.size() - 1 - m_d];
          m_v    = m_s[8];
          m_data = m_s[8] ? m_s[7:0] : 8'h00;
        end else begin
          m_v    = 1'b0;
          m_data = '0;
        end
      end
    end
    #1;
    check("ovalid", 32'(bus.ovalid), 32'(m_v));
    check("odata", 32'(bus.odata), 32'(m_data));
    check("cfg_busy", 32'(bus.cfg_busy), 32'(m_fc < m_d));
    check("cur_delay", 32'(bus.cur_delay), 32'(m_d));
  end

  // Apply inputs at a negedge and return at the following negedge.
  task automatic step(input bit ce, input bit v, input logic [7:0] d,
                      input bit ld, input logic [DW-1:0] cd);
    bus.ce        = ce;
    bus.ivalid    = v;
    bus.idata     = d;
    bus.cfg_load  = ld;
    bus.cfg_delay = cd;
    @(negedge clk);
  endtask

  function automatic logic [7:0] toggle_pat(input longint t0);
    return ((($time - t0) / 21) % 2 == 0) ? 8'hF0 : 8'h0F;
  endfunction

  initial begin
    logic [7:0] s0, s1, d;
    longint     t0;
    bit         cep [7] = '{1, 0, 0, 1, 1, 0, 1};

    bus.ce = 0; bus.ivalid = 0; bus.idata = 0; bus.cfg_load = 0; bus.cfg_delay = 0;
    @(negedge clk);
    check("rst_ovalid", 32'(bus.ovalid), 32'd0);
    check("rst_odata", 32'(bus.odata), 32'd0);
    check("rst_busy", 32'(bus.cfg_busy), 32'd1);
    check("rst_cur_delay", 32'(bus.cur_delay), 32'(DEFD));
    rst = 1'b0;

    // 1: D=1, toggling data
    t0 = $time;
    s0 = toggle_pat(t0);
    step(1, 1, s0, 0, 0);
    check("s1_busy_drop", 32'(bus.cfg_busy), 32'd0);
    s1 = toggle_pat(t0);
    step(1, 1, s1, 0, 0);
    check("s1_first_data", 32'(bus.odata), 32'(s0));
    check("s1_first_valid", 32'(bus.ovalid), 32'd1);
    repeat (18) step(1, 1, toggle_pat(t0), 0, 0);

    // 2: load 5, ramp
    step(1, 0, 8'h00, 1, 5);
    check("s2_cur_delay", 32'(bus.cur_delay), 32'd5);
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, 8'(i), 0, 0);
      if (i == 5) check("s2_still_empty", 32'(bus.ovalid), 32'd0);
      if (i == 6) begin
        check("s2_first_ramp", 32'(bus.odata), 32'h01);
        check("s2_first_valid", 32'(bus.ovalid), 32'd1);
      end
    end

    // 3: request 20 -> 16, wrap and read-before-write collision
    step(1, 1, 8'hA5, 1, 20);
    check("s3_clamp_hi", 32'(bus.cur_delay), 32'd16);
    s0 = 8'($urandom);
    step(1, 1, s0, 0, 0);
    for (int i = 2; i <= 40; i++) begin
      step(1, 1, 8'($urandom), 0, 0);
      if (i == 15) check("s3_not_full", 32'(bus.cfg_busy), 32'd1);
      if (i == 16) check("s3_collision", 32'(bus.odata), 32'hA5);
      if (i == 17) check("s3_wrap", 32'(bus.odata), 32'(s0));
    end
    step(1, 1, 8'($urandom), 1, 0);
    check("s3_clamp_lo", 32'(bus.cur_delay), 32'd1);
    repeat (4) step(1, 1, 8'($urandom), 0, 0);

    // 4: D=4 with gapped ce
    step(1, 1, 8'($urandom), 1, 4);
    for (int i = 0; i < 35; i++) step(cep[i % 7], 1, 8'($urandom), 0, 0);

    // 5: D=3, ivalid pattern 1,0,1,1
    step(1, 1, 8'($urandom), 1, 3);
    for (int i = 0; i < 20; i++) step(1, (i % 4) != 1, 8'($urandom), 0, 0);

    // random mix, including loads above MAX_DELAY and with ce low
    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), d,
           $urandom_range(0, 29) == 0, DW'($urandom_range(0, 31)));
    end

    // 6: async reset mid-stream, then refill and load during refill
    step(1, 1, 8'h00, 1, 1);
    repeat (6) step(1, 1, 8'($urandom), 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("s6_async_ovalid", 32'(bus.ovalid), 32'd0);
    check("s6_async_odata", 32'(bus.odata), 32'd0);
    check("s6_async_busy", 32'(bus.cfg_busy), 32'd1);
    check("s6_async_delay", 32'(bus.cur_delay), 32'(DEFD));
    @(negedge clk);
    rst = 1'b0;
    t0 = $time;
    step(1, 1, toggle_pat(t0), 0, 0);
    check("s6_refill_busy", 32'(bus.cfg_busy), 32'd0);
    repeat (9) step(1, 1, toggle_pat(t0), 0, 0);
    step(1, 1, 8'($urandom), 1, 6);
    repeat (3) step(1, 1, 8'($urandom), 0, 0);
    step(1, 1, 8'($urandom), 1, 6);
    check("s6_reload_busy", 32'(bus.cfg_busy), 32'd1);
    repeat (5) step(1, 1, 8'($urandom), 0, 0);
    check("s6_restart_busy", 32'(bus.cfg_busy), 32'd1);
    step(1, 1, 8'($urandom), 0, 0);
    check("s6_restart_done", 32'(bus.cfg_busy), 32'd0);
    repeat (4) step(1, 1, 8'($urandom), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
Parametrised successor of the fixed delay_line: delays an N-bit data word plus a valid flag by a run-time programmable number of clock-enabled cycles, 1..MAX_DELAY. It adds a clock enable, valid tracking and a flush/refill sequence on delay reconfiguration. It sits in the datapath wherever streams need alignment, with the delay set by control logic rather than fixed at synthesis.

Parameters:
N, 8, data width in bits
MAX_DELAY, 16, largest programmable delay in ce-cycles; must be >= 1
DEFAULT_DELAY, 1, active delay after reset; must be in 1..MAX_DELAY
DW, $clog2(MAX_DELAY+1), width of the delay configuration field (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ce  in  1  clock enable; storage advances only when 1
idata  in  N  input data word
ivalid  in  1  input data valid
cfg_delay  in  DW  requested delay, sampled when cfg_load=1
cfg_load  in  1  single-cycle strobe; applies cfg_delay at this edge, independent of ce
odata  out  N  delayed data; forced 0 while ovalid=0
ovalid  out  1  delayed valid
cfg_busy  out  1  1 while refilling after reset or reconfiguration
cur_delay  out  DW  currently active delay

Behaviour:
- Reset (async assert, sync release): odata=0, ovalid=0, cfg_busy=1, cur_delay=DEFAULT_DELAY. Write pointer and fill counter are 0; stored valid bits are all 0.
- Storage: circular buffer of MAX_DELAY entries, each holding {ivalid, idata}, with a write pointer wp.
- On each edge with ce=1: write {ivalid,idata} at wp; wp <= (wp==MAX_DELAY-1) ? 0 : wp+1. Wrap-around is explicit, not a power-of-2 mask.
- Read index = (wp - cur_delay) mod MAX_DELAY. Outputs are registered.
- Latency contract: the sample presented on the k-th ce=1 edge appears on odata/ovalid after the (k+cur_delay)-th ce=1 edge. With ce tied high, a sample at edge t is visible after edge t+D.
- ce=0: all state holds, including outputs, pointers and the fill counter.
- Fill counter fc counts ce=1 edges and saturates at cur_delay. While fc<cur_delay: cfg_busy=1, ovalid=0, odata=0. cfg_busy=0 once fc==cur_delay.
- cfg_load=1 at an edge:
  - cur_delay <= clamp(cfg_delay). Values of 0 become 1; values above MAX_DELAY become MAX_DELAY.
  - fc <= 0, cfg_busy <= 1, and ovalid/odata are cleared on that edge. Stale data is never emitted under the new delay.
  - The buffer write on that edge still happens if ce=1.
- cfg_load with the same value as cur_delay still flushes.
- cfg_load together with rst: rst wins.
- Back-to-back cfg_load: the last one wins; refill restarts each time.
- D=MAX_DELAY: the read index equals wp, so the read must use the old contents of that entry (read-before-write). The implementation must guarantee this.
- ivalid=0 samples propagate as ovalid=0 with odata=0; idata is don't-care when ivalid=0.

Decomposition:
- Package prog_delay_pkg:
  - the DW derivation
  - function clamp_delay(cfg, MAX_DELAY)
  - function ptr_wrap(ptr, MAX_DELAY)
- One sub-module, delay_ram:
  - MAX_DELAY x (N+1) storage
  - synchronous write, registered read with read-before-write on address collision
  - may infer distributed RAM
- Top module holds the pointers, fill counter, clamp logic and output gating.

Test Plan:
1. Reset then ce=1 constantly, D=1, ivalid=1 toggling idata 0xF0/0x0F every 21 ns on a 4 ns clock -> odata equals idata delayed exactly one edge; cfg_busy drops after the first edge; ovalid=1 thereafter.
2. cfg_load with cfg_delay=5, then a ramp 0x01,0x02,... -> ovalid=0 for 5 edges after load; then odata=0x01 on the 5th edge after the 0x01 sample; cur_delay=5.
3. D=MAX_DELAY=16 and D=0 requested -> cur_delay=16 and 1 respectively; the 16-cycle case checks the wrap-around and read-before-write collision (sample k reappears exactly at edge k+16).
4. D=4, ce pattern 1,0,0,1,1,0,1,... -> outputs hold when ce=0; each sample emerges after exactly 4 ce=1 edges regardless of gaps.
5. D=3 mid-stream, ivalid pattern 1,0,1,1 -> ovalid pattern identical, shifted 3 edges; odata=0 where ovalid=0.
6. Async rst pulse between clock edges mid-stream -> outputs clear immediately; cur_delay=DEFAULT_DELAY; cfg_busy=1; the refill contract from scenario 1 holds afterwards. Also cfg_load during refill -> refill restarts from 0.
